// File: rtl/board_pkg.sv
// Shared board constants, hue index type and hue names used by the
// button controller and the hue-to-RGB LUT.
package board_pkg;

    localparam int CLOCK_FREQ_HZ = 12_000_000;
    localparam int NUM_HUES      = 6;

    typedef logic [2:0] hue_t;

    typedef enum logic [2:0] {
        RED,
        YELLOW,
        GREEN,
        CYAN,
        BLUE,
        MAGENTA
    } hue_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PRESSED,
        S_HELD
    } press_state_e;

    function automatic hue_t hue_next(input hue_t h, input int n);
        if (int'(h) >= n - 1) begin
            return '0;
        end
        return h + 3'd1;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser and stability counter for an active-low button;
// emits the accepted level (1 = pressed) and one-cycle edge strobes.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 120_000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_n,
    output logic btn_level,
    output logic btn_rise,
    output logic btn_fall
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          level_q, level_d;
    logic          rise_q, rise_d;
    logic          fall_q, fall_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          pressed_s;

    assign pressed_s = ~sync2_q;

    always_comb begin
        sync1_d = btn_n;
        sync2_d = sync1_q;
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        cnt_d   = '0;
        // Count only while the input disagrees with the accepted level.
        if (pressed_s != level_q) begin
            if (cnt_q >= CNT_MAX) begin
                level_d = ~level_q;
                rise_d  = ~level_q;
                fall_d  = level_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            cnt_q   <= cnt_d;
        end
    end

    assign btn_level = level_q;
    assign btn_rise  = rise_q;
    assign btn_fall  = fall_q;

endmodule

// File: rtl/button_hue_ctrl.sv
// Short/long press decoder driving the hue index; define AUTO_ADVANCE_EN
// to also step the hue once per CLOCK_FREQ cycles while the button is idle.
module button_hue_ctrl
    import board_pkg::*;
#(
    parameter int CLOCK_FREQ        = board_pkg::CLOCK_FREQ_HZ,
    parameter int DEBOUNCE_CYCLES   = 120_000,
    parameter int LONG_PRESS_CYCLES = 12_000_000,
    parameter int NUM_HUES          = board_pkg::NUM_HUES
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_n,
    output logic [2:0] hue_index,
    output logic       btn_level,
    output logic       short_pulse,
    output logic       long_pulse
);

    localparam int HW = (LONG_PRESS_CYCLES > 1) ? $clog2(LONG_PRESS_CYCLES) : 1;
    localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_PRESS_CYCLES - 1);

    logic btn_rise;
    logic btn_fall;
    logic tick;

    press_state_e  state_q, state_d;
    logic [HW-1:0] hold_q, hold_d;
    hue_t          hue_q, hue_d;
    logic          short_q, short_d;
    logic          long_q, long_d;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk      (clk),
        .rst      (rst),
        .btn_n    (btn_n),
        .btn_level(btn_level),
        .btn_rise (btn_rise),
        .btn_fall (btn_fall)
    );

`ifdef AUTO_ADVANCE_EN
    localparam int TW = (CLOCK_FREQ > 1) ? $clog2(CLOCK_FREQ) : 1;
    localparam logic [TW-1:0] TICK_MAX = TW'(CLOCK_FREQ - 1);

    logic [TW-1:0] timer_q, timer_d;

    // Runs only in IDLE; an accepted press restarts the idle period.
    always_comb begin
        timer_d = '0;
        tick    = 1'b0;
        if (state_q == S_IDLE && !btn_rise) begin
            if (timer_q >= TICK_MAX) begin
                tick = 1'b1;
            end else begin
                timer_d = timer_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end
`else
    assign tick = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        hue_d   = hue_q;
        short_d = 1'b0;
        long_d  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (btn_rise) begin
                    state_d = S_PRESSED;
                    hold_d  = '0;
                end
            end
            S_PRESSED: begin
                if (hold_q >= HOLD_MAX) begin
                    state_d = S_HELD;
                    long_d  = 1'b1;
                    hue_d   = '0;
                end else if (btn_fall) begin
                    state_d = S_IDLE;
                    short_d = 1'b1;
                    hue_d   = hue_next(hue_q, NUM_HUES);
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            S_HELD: begin
                // Level test also covers a release coinciding with the threshold.
                if (!btn_level) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (tick && !short_d) begin
            hue_d = hue_next(hue_q, NUM_HUES);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            hold_q  <= '0;
            hue_q   <= '0;
            short_q <= 1'b0;
            long_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            hue_q   <= hue_d;
            short_q <= short_d;
            long_q  <= long_d;
        end
    end

    assign hue_index   = hue_q;
    assign short_pulse = short_q;
    assign long_pulse  = long_q;

endmodule
